// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller feeding a 16-bit ALU: fetches operands from an 8x16
// register file, drives the ALU, and retires results into the regfile and NZCV flags.
module alu_exec_ctrl #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    output logic [3:0]    alu_c,
    input  logic [DW-1:0] alu_z,
    input  logic          alu_cout,
    input  logic          alu_ovf,
    input  logic          alu_lt,
    input  logic          alu_eq,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic [3:0]    flags,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDI = 4'b1001;

    state_t        state;
    logic [15:0]   instr_q;
    logic [DW-1:0] regs [NREGS];

    logic [3:0]    op;
    logic [2:0]    rd, rs1, rs2;
    logic [8:0]    imm;
    logic          new_legal;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:9];
    assign rs1 = instr_q[8:6];
    assign rs2 = instr_q[5:3];
    assign imm = instr_q[8:0];

    always_comb begin
        new_legal = 1'b0;
        case (in_instr[15:12])
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_CMP, OP_LDI: new_legal = 1'b1;
            default: new_legal = 1'b0;
        endcase
    end

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            instr_q  <= '0;
            in_ready <= 1'b1;
            alu_x    <= '0;
            alu_y    <= '0;
            alu_c    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            flags    <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr_q  <= in_instr;
                        in_ready <= 1'b0;
                        // Illegal opcodes skip straight to retire with the error pulse.
                        if (new_legal) begin
                            state <= READ;
                        end else begin
                            state <= WB;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (op != OP_LDI) begin
                        alu_x <= regs[rs1];
                        alu_y <= regs[rs2];
                        alu_c <= (op == OP_CMP) ? OP_SUB : op;
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    if (op == OP_LDI) begin
                        regs[rd] <= {{(DW-9){1'b0}}, imm};
                        result   <= {{(DW-9){1'b0}}, imm};
                    end else if (op == OP_CMP) begin
                        flags <= {alu_lt, alu_eq, alu_cout, alu_ovf};
                    end else begin
                        regs[rd] <= alu_z;
                        result   <= alu_z;
                        flags    <= {alu_z[DW-1], (alu_z == '0), alu_cout, alu_ovf};
                    end
                    state <= WB;
                    done  <= 1'b1;
                end
                WB: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU on the x/y/c/z interface.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [3:0]  alu_c;
    logic        alu_cout, alu_ovf, alu_lt, alu_eq;
    logic        done, err;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.NREGS(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c),
        .alu_z(alu_z), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .alu_lt(alu_lt), .alu_eq(alu_eq),
        .done(done), .err(err), .result(result), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: SUB/CMP carry is the carry out of x + ~y + 1 (1 = no borrow).
    logic [16:0] sum;
    always_comb begin
        sum      = 17'd0;
        alu_z    = 16'h0000;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_lt   = (alu_x < alu_y);
        alu_eq   = (alu_x == alu_y);
        case (alu_c)
            4'b0000: alu_z = alu_x & alu_y;
            4'b0001: alu_z = alu_x | alu_y;
            4'b0010: begin
                sum      = {1'b0, alu_x} + {1'b0, alu_y};
                alu_z    = sum[15:0];
                alu_cout = sum[16];
                alu_ovf  = (alu_x[15] == alu_y[15]) && (sum[15] != alu_x[15]);
            end
            4'b0011: begin
                sum      = {1'b0, alu_x} + {1'b0, ~alu_y} + 17'd1;
                alu_z    = sum[15:0];
                alu_cout = sum[16];
                alu_ovf  = (alu_x[15] != alu_y[15]) && (sum[15] != alu_x[15]);
            end
            4'b0111: alu_z = {15'd0, alu_x < alu_y};
            default: alu_z = 16'h0000;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (k == 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  dreg;
        logic [15:0] dval;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        er;
        logic        alu;
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  c;
    } vec_t;

    vec_t tv[12];
    int   lat, hs, dn, t1, t2;
    logic hs_now, saw_done;

    initial begin
        //          instr     dreg  dval      result    flags    er    alu   x         y         c
        tv[0]  = '{16'h9205, 3'd1, 16'h0005, 16'h0005, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0}; // LDI r1,#5
        tv[1]  = '{16'h9403, 3'd2, 16'h0003, 16'h0003, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0}; // LDI r2,#3
        tv[2]  = '{16'h2650, 3'd3, 16'h0008, 16'h0008, 4'b0000, 1'b0, 1'b1, 16'h0005, 16'h0003, 4'h2}; // ADD r3,r1,r2
        tv[3]  = '{16'h3848, 3'd4, 16'h0000, 16'h0000, 4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0005, 4'h3}; // SUB r4,r1,r1
        tv[4]  = '{16'h8088, 3'd0, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1'b1, 16'h0003, 16'h0005, 4'h3}; // CMP r2,r1
        tv[5]  = '{16'hF200, 3'd1, 16'h0005, 16'h0000, 4'b1000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'h0}; // illegal 1111
        tv[6]  = '{16'h1A50, 3'd5, 16'h0007, 16'h0007, 4'b0000, 1'b0, 1'b1, 16'h0005, 16'h0003, 4'h1}; // OR r5,r1,r2
        tv[7]  = '{16'h0C50, 3'd6, 16'h0001, 16'h0001, 4'b0000, 1'b0, 1'b1, 16'h0005, 16'h0003, 4'h0}; // AND r6,r1,r2
        tv[8]  = '{16'h9FFF, 3'd7, 16'h01FF, 16'h01FF, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0}; // LDI r7,#1FF
        tv[9]  = '{16'h3088, 3'd0, 16'hFFFE, 16'hFFFE, 4'b1000, 1'b0, 1'b1, 16'h0003, 16'h0005, 4'h3}; // SUB r0,r2,r1
        tv[10] = '{16'h7288, 3'd1, 16'h0001, 16'h0001, 4'b0000, 1'b0, 1'b1, 16'h0003, 16'h0005, 4'h7}; // SLT r1,r2,r1
        tv[11] = '{16'h2400, 3'd2, 16'hFFFC, 16'hFFFC, 4'b1010, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 4'h2}; // ADD r2,r0,r0

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_err",    {31'd0, err},  32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags",  {28'd0, flags},  32'd0);
        chk("rst_alu_x",  {16'd0, alu_x},  32'd0);
        chk("rst_alu_y",  {16'd0, alu_y},  32'd0);
        chk("rst_alu_c",  {28'd0, alu_c},  32'd0);
        chk("rst_r0",     {16'd0, dbg_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            wait_ready();
            dbg_addr = tv[i].dreg;
            in_instr = tv[i].instr;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (done) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("v%0d_latency", i), lat, tv[i].er ? 32'd1 : 32'd3);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tv[i].er});
            chk($sformatf("v%0d_reg", i), {16'd0, dbg_data}, {16'd0, tv[i].dval});
            chk($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, tv[i].res});
            chk($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, tv[i].flg});
            if (tv[i].alu) begin
                chk($sformatf("v%0d_alu_x", i), {16'd0, alu_x}, {16'd0, tv[i].x});
                chk($sformatf("v%0d_alu_y", i), {16'd0, alu_y}, {16'd0, tv[i].y});
                chk($sformatf("v%0d_alu_c", i), {28'd0, alu_c}, {28'd0, tv[i].c});
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // in_valid held through the busy window: LDI r3,#9 then ADD r4,r3,r3
        wait_ready();
        dbg_addr = 3'd4;
        in_instr = 16'h9609;
        in_valid = 1'b1;
        hs = 0; dn = 0; t1 = -1; t2 = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            hs_now = in_ready && in_valid;
            if (hs_now) begin
                hs++;
                if (hs == 1) t1 = cyc; else t2 = cyc;
            end
            @(posedge clk);
            #1;
            if (hs_now) begin
                if (hs == 1) in_instr = 16'h28D8;
                else in_valid = 1'b0;
            end
            @(negedge clk);
            if (done) dn++;
        end
        in_valid = 1'b0;
        chk("held_handshakes", hs, 32'd2);
        chk("held_retires", dn, 32'd2);
        chk("held_spacing", t2 - t1, 32'd4);
        chk("held_r4", {16'd0, dbg_data}, 32'h0012);

        // Reset asserted while ADD r5,r3,r3 is in EXEC
        wait_ready();
        dbg_addr = 3'd5;
        in_instr = 16'h2AD8;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_flags",  {28'd0, flags},  32'd0);
        chk("abort_alu_x",  {16'd0, alu_x},  32'd0);
        chk("abort_alu_c",  {28'd0, alu_c},  32'd0);
        chk("abort_r5",     {16'd0, dbg_data}, 32'd0);
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_r5_after", {16'd0, dbg_data}, 32'd0);
        dbg_addr = 3'd3;
        #1 chk("abort_r3_cleared", {16'd0, dbg_data}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
